// File: rtl/spi_peripheral_rx_if.sv
// SPI pin group plus the sys_clk-domain reply/receive handshake of spi_peripheral_rx.
interface spi_peripheral_rx_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  logic                            i_SPI_Clk;
  logic                            i_SPI_MOSI;
  logic                            i_SPI_CS_n;
  logic                            o_SPI_MISO;
  logic                            o_MISO_En;
  logic [7:0]                      i_TX_Byte;
  logic                            i_TX_DV;
  logic [7:0]                      o_RX_Byte;
  logic                            o_RX_DV;
  logic [1:0]                      o_RX_Index;
  logic [8*MAX_BYTES_PER_CS-1:0]   o_Word;
  logic                            o_Word_DV;
  logic                            o_Frame_Err;
  logic                            o_Overrun;

  modport master (
    output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, i_TX_Byte, i_TX_DV,
    input  o_SPI_MISO, o_MISO_En, o_RX_Byte, o_RX_DV, o_RX_Index,
           o_Word, o_Word_DV, o_Frame_Err, o_Overrun
  );

  modport slave (
    input  i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, i_TX_Byte, i_TX_DV,
    output o_SPI_MISO, o_MISO_En, o_RX_Byte, o_RX_DV, o_RX_Index,
           o_Word, o_Word_DV, o_Frame_Err, o_Overrun
  );
endinterface

// File: rtl/spi_peripheral_rx.sv
// Oversampling SPI mode-0 peripheral: receives bytes on MOSI, assembles per-CS words,
// and shifts a reply byte out on MISO, all in the sys_clk domain.
module spi_peripheral_rx #(
  parameter int MAX_BYTES_PER_CS = 2
) (
  input  logic                sys_clk,
  input  logic                i_Rst_L,
  spi_peripheral_rx_if.slave  bus
);
  localparam int         WORD_W   = 8 * MAX_BYTES_PER_CS;
  localparam logic [2:0] MAX_CNT  = 3'(MAX_BYTES_PER_CS);
  localparam logic [2:0] LAST_CNT = 3'(MAX_BYTES_PER_CS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [WORD_W-1:0] insert_byte(input logic [WORD_W-1:0] w,
                                                    input logic [2:0]        idx,
                                                    input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    for (int s = 0; s < MAX_BYTES_PER_CS; s++)
      if (s == MAX_BYTES_PER_CS - 1 - int'(idx)) r[8*s +: 8] = b;
    return r;
  endfunction

  function automatic logic [1:0] sat_index(input logic [2:0] cnt);
    return (cnt > 3'd3) ? 2'd3 : cnt[1:0];
  endfunction

  state_t            state;
  logic              sck_p0, sck_p1, sck_p2;
  logic              mosi_p0, mosi_p1;
  logic              cs_p0, cs_p1, cs_p2;
  logic [1:0]        warm;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [7:0]        rx_shift;
  logic [WORD_W-1:0] word_acc;
  logic [7:0]        tx_hold;
  logic [7:0]        tx_shift;
  logic              reload;

  logic              warm_done, sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]        rx_full;
  logic [WORD_W-1:0] word_ins;

  // Edges are only trusted once all three sync stages hold sampled pin values,
  // so a CS_n held low across reset release is not mistaken for a new frame.
  assign warm_done = (warm == 2'd3);
  assign sck_rise  = warm_done &  sck_p1 & ~sck_p2;
  assign sck_fall  = warm_done & ~sck_p1 &  sck_p2;
  assign cs_rise   = warm_done &  cs_p1  & ~cs_p2;
  assign cs_fall   = warm_done & ~cs_p1  &  cs_p2;
  assign rx_full   = {rx_shift[6:0], mosi_p1};
  assign word_ins  = insert_byte(word_acc, byte_cnt, rx_full);

  assign bus.o_SPI_MISO = tx_shift[7];

  always_ff @(posedge sys_clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state           <= IDLE;
      sck_p0          <= 1'b0;  sck_p1  <= 1'b0;  sck_p2 <= 1'b0;
      mosi_p0         <= 1'b0;  mosi_p1 <= 1'b0;
      cs_p0           <= 1'b1;  cs_p1   <= 1'b1;  cs_p2  <= 1'b1;
      warm            <= 2'd0;
      bit_cnt         <= 3'd0;
      byte_cnt        <= 3'd0;
      rx_shift        <= 8'h00;
      word_acc        <= '0;
      tx_hold         <= 8'h00;
      tx_shift        <= 8'h00;
      reload          <= 1'b0;
      bus.o_MISO_En   <= 1'b0;
      bus.o_RX_Byte   <= 8'h00;
      bus.o_RX_DV     <= 1'b0;
      bus.o_RX_Index  <= 2'd0;
      bus.o_Word      <= '0;
      bus.o_Word_DV   <= 1'b0;
      bus.o_Frame_Err <= 1'b0;
      bus.o_Overrun   <= 1'b0;
    end else begin
      // sync stage boundary: pins -> p0 -> p1 -> p2
      sck_p0  <= bus.i_SPI_Clk;   sck_p1  <= sck_p0;  sck_p2 <= sck_p1;
      mosi_p0 <= bus.i_SPI_MOSI;  mosi_p1 <= mosi_p0;
      cs_p0   <= bus.i_SPI_CS_n;  cs_p1   <= cs_p0;   cs_p2  <= cs_p1;
      if (!warm_done) warm <= warm + 2'd1;

      bus.o_RX_DV     <= 1'b0;
      bus.o_Word_DV   <= 1'b0;
      bus.o_Frame_Err <= 1'b0;
      bus.o_MISO_En   <= ~cs_p1;

      if (bus.i_TX_DV) tx_hold <= bus.i_TX_Byte;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            word_acc <= '0;
            tx_shift <= tx_hold;
            reload   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (sck_rise) begin
            rx_shift <= rx_full;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.o_RX_Byte  <= rx_full;
              bus.o_RX_DV    <= 1'b1;
              bus.o_RX_Index <= sat_index(byte_cnt);
              reload         <= 1'b1;
              if (byte_cnt < MAX_CNT) begin
                word_acc <= word_ins;
                if (byte_cnt == LAST_CNT) begin
                  bus.o_Word    <= word_ins;
                  bus.o_Word_DV <= 1'b1;
                end
              end else begin
                bus.o_Overrun <= 1'b1;
              end
              if (byte_cnt != 3'd4) byte_cnt <= byte_cnt + 3'd1;
            end
          end
          // The fall after a completed byte starts the next reply byte.
          if (sck_fall) begin
            if (reload) begin
              tx_shift <= tx_hold;
              reload   <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            if (sck_rise ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0))
              bus.o_Frame_Err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Directed bench for spi_peripheral_rx: bit-banged SPI master, strobe monitor and
// immediate-assertion checks against hand-computed values.
module tb_spi_peripheral_rx;
  localparam int MAX = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spi_peripheral_rx_if #(.MAX_BYTES_PER_CS(MAX)) bus();

  spi_peripheral_rx #(.MAX_BYTES_PER_CS(MAX)) dut (
    .sys_clk (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Strobe log, sampled on the falling edge
  int               rx_n = 0;
  int               wd_n = 0;
  int               fe_n = 0;
  logic [7:0]       rx_log  [0:63];
  logic [1:0]       idx_log [0:63];
  logic [8*MAX-1:0] last_word = '0;

  always @(negedge clk) begin
    if (bus.o_RX_DV === 1'b1) begin
      if (rx_n < 64) begin
        rx_log[rx_n]  = bus.o_RX_Byte;
        idx_log[rx_n] = bus.o_RX_Index;
      end
      rx_n++;
    end
    if (bus.o_Word_DV === 1'b1) begin
      wd_n++;
      last_word = bus.o_Word;
    end
    if (bus.o_Frame_Err === 1'b1) fe_n++;
  end

  int base_rx, base_wd, base_fe;

  task automatic snap();
    base_rx = rx_n;
    base_wd = wd_n;
    base_fe = fe_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input logic [7:0] b);
    bus.i_TX_Byte = b;
    bus.i_TX_DV   = 1'b1;
    clks(1);
    bus.i_TX_DV   = 1'b0;
  endtask

  task automatic cs_low();
    bus.i_SPI_CS_n = 1'b0;
    clks(6);
  endtask

  task automatic cs_high();
    clks(2);
    bus.i_SPI_CS_n = 1'b1;
    clks(8);
  endtask

  // SCK half period is 4 sys_clk; on the 8th rise the RX_DV latency is checked.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input int load_at,
                          input logic [7:0] load_val, output logic [7:0] miso);
    logic early, on;
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.i_SPI_MOSI = b[7-i];
      if (i == load_at) begin
        tx_load(load_val);
        clks(3);
      end else begin
        clks(4);
      end
      miso[7-i] = bus.o_SPI_MISO;
      bus.i_SPI_Clk = 1'b1;
      if (i == 7) begin
        clks(2);
        early = bus.o_RX_DV;
        clks(1);
        on = bus.o_RX_DV;
        clks(1);
        chk("rx_dv_before_edge3", early, 1'b0);
        chk("rx_dv_after_edge3", on, 1'b1);
      end else begin
        clks(4);
      end
      bus.i_SPI_Clk = 1'b0;
    end
    clks(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_dv"},   bus.o_RX_DV, 1'b0);
    chk({tag, "_rx_byte"}, bus.o_RX_Byte, 8'h00);
    chk({tag, "_rx_idx"},  bus.o_RX_Index, 2'd0);
    chk({tag, "_word"},    bus.o_Word, 16'h0000);
    chk({tag, "_word_dv"}, bus.o_Word_DV, 1'b0);
    chk({tag, "_ferr"},    bus.o_Frame_Err, 1'b0);
    chk({tag, "_overrun"}, bus.o_Overrun, 1'b0);
    chk({tag, "_miso"},    bus.o_SPI_MISO, 1'b0);
    chk({tag, "_miso_en"}, bus.o_MISO_En, 1'b0);
  endtask

  logic [7:0] m0, m1, m2;

  initial begin
    bus.i_SPI_Clk  = 1'b0;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_SPI_CS_n = 1'b1;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_DV    = 1'b0;

    // Reset state
    clks(4);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    clks(6);

    // Single byte 1C, no reply loaded
    snap();
    cs_low();
    chk("miso_en_in_frame", bus.o_MISO_En, 1'b1);
    spi_bits(8'h1C, 8, -1, 8'h00, m0);
    cs_high();
    chk("f1_rx_count", rx_n - base_rx, 1);
    chk("f1_rx_byte", rx_log[base_rx], 8'h1C);
    chk("f1_rx_idx", idx_log[base_rx], 2'd0);
    chk("f1_word_dv_count", wd_n - base_wd, 0);
    chk("f1_ferr_count", fe_n - base_fe, 0);
    chk("f1_miso", m0, 8'h00);
    chk("miso_en_after_frame", bus.o_MISO_En, 1'b0);

    // BE, EF -> word BEEF
    snap();
    cs_low();
    spi_bits(8'hBE, 8, -1, 8'h00, m0);
    spi_bits(8'hEF, 8, -1, 8'h00, m1);
    cs_high();
    chk("f2_rx_count", rx_n - base_rx, 2);
    chk("f2_byte0", rx_log[base_rx], 8'hBE);
    chk("f2_idx0", idx_log[base_rx], 2'd0);
    chk("f2_byte1", rx_log[base_rx+1], 8'hEF);
    chk("f2_idx1", idx_log[base_rx+1], 2'd1);
    chk("f2_word_dv_count", wd_n - base_wd, 1);
    chk("f2_word_at_dv", last_word, 16'hBEEF);
    chk("f2_word_out", bus.o_Word, 16'hBEEF);
    chk("f2_overrun", bus.o_Overrun, 1'b0);

    // Reply A5 reloaded for both bytes
    tx_load(8'hA5);
    cs_low();
    spi_bits(8'h5A, 8, -1, 8'h00, m0);
    spi_bits(8'hC3, 8, -1, 8'h00, m1);
    cs_high();
    chk("f3_miso0", m0, 8'hA5);
    chk("f3_miso1", m1, 8'hA5);
    chk("f3_word", bus.o_Word, 16'h5AC3);

    // 3C loaded during byte 0 shows up in byte 1
    cs_low();
    spi_bits(8'h12, 8, 3, 8'h3C, m0);
    spi_bits(8'h34, 8, -1, 8'h00, m1);
    cs_high();
    chk("f4_miso0", m0, 8'hA5);
    chk("f4_miso1", m1, 8'h3C);

    // Partial byte of 5 bits, then a clean frame
    snap();
    cs_low();
    spi_bits(8'hA0, 5, -1, 8'h00, m0);
    cs_high();
    chk("f5_ferr_count", fe_n - base_fe, 1);
    chk("f5_rx_count", rx_n - base_rx, 0);
    snap();
    cs_low();
    spi_bits(8'h1C, 8, -1, 8'h00, m0);
    cs_high();
    chk("f6_rx_count", rx_n - base_rx, 1);
    chk("f6_rx_byte", rx_log[base_rx], 8'h1C);
    chk("f6_rx_idx", idx_log[base_rx], 2'd0);
    chk("f6_ferr_count", fe_n - base_fe, 0);

    // Three bytes into a two-byte word -> overrun
    snap();
    cs_low();
    spi_bits(8'h11, 8, -1, 8'h00, m0);
    spi_bits(8'h22, 8, -1, 8'h00, m1);
    chk("f7_overrun_before", bus.o_Overrun, 1'b0);
    spi_bits(8'h33, 8, -1, 8'h00, m2);
    cs_high();
    chk("f7_rx_count", rx_n - base_rx, 3);
    chk("f7_byte2", rx_log[base_rx+2], 8'h33);
    chk("f7_idx2", idx_log[base_rx+2], 2'd2);
    chk("f7_word_dv_count", wd_n - base_wd, 1);
    chk("f7_word_at_dv", last_word, 16'h1122);
    chk("f7_word_out", bus.o_Word, 16'h1122);
    chk("f7_overrun", bus.o_Overrun, 1'b1);
    chk("f7_ferr_count", fe_n - base_fe, 0);
    clks(20);
    chk("f7_overrun_sticky", bus.o_Overrun, 1'b1);

    // Reset in the middle of a frame
    snap();
    cs_low();
    spi_bits(8'hF0, 4, -1, 8'h00, m0);
    rst_n = 1'b0;
    bus.i_SPI_CS_n = 1'b1;
    clks(3);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    clks(10);
    chk("midrst_rx_count", rx_n - base_rx, 0);
    chk("midrst_ferr_count", fe_n - base_fe, 0);
    chk("midrst_word_dv_count", wd_n - base_wd, 0);
    snap();
    cs_low();
    spi_bits(8'hEF, 8, -1, 8'h00, m0);
    cs_high();
    chk("f8_rx_count", rx_n - base_rx, 1);
    chk("f8_rx_byte", rx_log[base_rx], 8'hEF);
    chk("f8_rx_idx", idx_log[base_rx], 2'd0);
    chk("f8_miso", m0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
